// File: rtl/bist_pkg.sv
// bist_pkg: shared types, polynomials and next-state helpers for the BIST driver.
//   state_t     - driver FSM states
//   LFSR5_TAPS  - taps of x^5+x^3+1 as used by the Fibonacci shift {q[3:0], fb}
//   MISR16_POLY - CCITT feedback polynomial
package bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [4:0]  LFSR5_TAPS  = 5'b10010;
    localparam logic [15:0] MISR16_POLY = 16'h1021;

    function automatic logic [4:0] lfsr_next(input logic [4:0] q);
        return {q[3:0], ^(q & LFSR5_TAPS)};
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] m, input logic d);
        return {m[14:0], 1'b0} ^ ((m[15] ^ d) ? MISR16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/bist_misr.sv
// bist_misr: single-input signature register (serial compactor).
//   i_clk, i_rst_n - clock, async active-low reset (clears signature)
//   i_load, i_seed - load seed (wins over i_en)
//   i_en, i_d      - shift in one response bit
//   o_sig          - current signature
module bist_misr
    import bist_pkg::*;
#(
    parameter int                 SIG_W = 16,
    parameter logic [SIG_W-1:0]   POLY  = SIG_W'(MISR16_POLY)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [SIG_W-1:0] i_seed,
    input  logic             i_en,
    input  logic             i_d,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_sig <= '0;
        else if (i_load)
            r_sig <= i_seed;
        else if (i_en)
            r_sig <= {r_sig[SIG_W-2:0], 1'b0} ^ ((r_sig[SIG_W-1] ^ i_d) ? POLY : '0);
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/fake_netlist_bist_driver.sv
// fake_netlist_bist_driver: LFSR pattern source + MISR compactor for one combinational cone.
//   i_clk, i_rst_n       - clock, async active-low reset
//   i_start, i_abort     - begin a run (IDLE/DONE only); abort to IDLE (priority)
//   o_dut_in, i_dut_out  - cone stimulus and cone response
//   o_busy, o_done       - run in progress (RUN/DRAIN); run finished (DONE)
//   o_pass, o_signature  - final signature matches EXP_SIG; MISR contents
module fake_netlist_bist_driver
    import bist_pkg::*;
#(
    parameter int               N_IN      = 5,
    parameter int               NUM_PAT   = 31,
    parameter logic [N_IN-1:0]  SEED      = 5'h01,
    parameter int               SIG_W     = 16,
    parameter logic [SIG_W-1:0] MISR_SEED = '0,
    parameter logic [SIG_W-1:0] EXP_SIG   = '0,
    parameter int               DUT_LAT   = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    output logic [N_IN-1:0]  o_dut_in,
    input  logic             i_dut_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [SIG_W-1:0] o_signature
);

    localparam int CNT_W = $clog2(NUM_PAT + 1);

    state_t           r_state;
    logic [N_IN-1:0]  r_lfsr;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_drain;
    logic             r_busy;
    logic             r_done;
    logic             w_start;
    logic             w_run;
    logic             w_last;
    logic             w_cap;
    logic [SIG_W-1:0] w_sig;

    assign w_start = i_start && (r_state == IDLE || r_state == DONE);
    assign w_run   = (r_state == RUN);
    // the cycle driving the final pattern; its response is captured on the closing edge
    assign w_last  = (r_cnt == CNT_W'(NUM_PAT - 1));

    // r_lfsr doubles as the registered dut_in: it stops advancing on the last
    // pattern so DRAIN and DONE hold that pattern on the cone inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_lfsr  <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_abort) begin
            r_state <= IDLE;
            r_lfsr  <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: if (i_start) begin
                    r_state <= RUN;
                    r_lfsr  <= SEED;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= (DUT_LAT > 0) ? DRAIN : DONE;
                        r_busy  <= (DUT_LAT > 0);
                        r_done  <= (DUT_LAT == 0);
                        r_drain <= '0;
                    end else begin
                        r_lfsr <= lfsr_next(r_lfsr);
                    end
                end
                DRAIN: begin
                    r_drain <= r_drain + 1'b1;
                    if (r_drain == 2'(DUT_LAT - 1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // valid bit travels with each pattern so the MISR sees exactly NUM_PAT responses
    generate
        if (DUT_LAT == 0) begin : g_nolat
            assign w_cap = w_run;
        end else begin : g_lat
            logic [DUT_LAT-1:0] r_vld;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    r_vld <= '0;
                else if (i_abort)
                    r_vld <= '0;
                else
                    r_vld <= (r_vld << 1) | DUT_LAT'(w_run);
            end
            assign w_cap = r_vld[DUT_LAT-1];
        end
    endgenerate

    bist_misr #(
        .SIG_W (SIG_W),
        .POLY  (SIG_W'(MISR16_POLY))
    ) u_misr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_start && !i_abort),
        .i_seed  (MISR_SEED),
        .i_en    (w_cap && !i_abort),
        .i_d     (i_dut_out),
        .o_sig   (w_sig)
    );

    assign o_dut_in    = r_lfsr;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_done && (w_sig == EXP_SIG);
    assign o_signature = w_sig;

endmodule
